// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause bit positions.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } reset_state_e;

   localparam int CAUSE_W        = 5;
   localparam int CAUSE_POR      = 0;
   localparam int CAUSE_PLL_LOSS = 1;
   localparam int CAUSE_BUTTON   = 2;
   localparam int CAUSE_SW       = 3;
   localparam int CAUSE_WDT      = 4;

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between software-side logic and the reset sequencer.
interface reset_sequencer_if #(
   parameter int NUM_DOMAINS = 3
);
   import reset_seq_pkg::*;

   // Requests are single-cycle pulses with no ready/ack: the sequencer samples them on every
   // clock edge and never stalls. Status outputs are registered and valid every cycle.
   logic                   sw_reset_req_i;
   logic                   wdt_kick_i;
   logic [NUM_DOMAINS-1:0] domain_reset_o;
   logic                   all_ready_o;
   logic [CAUSE_W-1:0]     reset_cause_o;

   modport master (
      output sw_reset_req_i, wdt_kick_i,
      input  domain_reset_o, all_ready_o, reset_cause_o
   );

   modport slave (
      input  sw_reset_req_i, wdt_kick_i,
      output domain_reset_o, all_ready_o, reset_cause_o
   );

endinterface

// File: rtl/reset_debounce.sv
// 2-FF synchroniser followed by a stability debouncer; with DEBOUNCE_CYCLES=1 the synchroniser
// output is used directly.
module reset_debounce #(
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic level_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], d_i};
   end

   generate
      if (DEBOUNCE_CYCLES == 1) begin : g_sync_only
         assign level_o = sync_q[1];
      end else begin : g_debounce
         localparam int CW = $clog2(DEBOUNCE_CYCLES);
         logic [CW-1:0] cnt_q;
         logic          level_q;

         // The level flips on the Nth consecutive cycle the synced input disagrees with it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q   <= '0;
               level_q <= 1'b0;
            end else if (sync_q[1] == level_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               cnt_q   <= '0;
               level_q <= sync_q[1];
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign level_o = level_q;
      end
   endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Staged multi-domain reset controller with cause recording.
// Optional watchdog compiled in with `define RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS      = 3,
   parameter int HOLD_CYCLES      = 31,
   parameter int STAGE_GAP_CYCLES = 16,
   parameter int DEBOUNCE_CYCLES  = 250000,
   parameter int KEY_WIDTH        = 4,
   parameter int KEY_VALUE        = 1,
   parameter int WDT_CYCLES       = 25000000
) (
   input  logic                 clk,
   input  logic                 reset_n_i,
   input  logic                 pll_locked_i,
   input  logic                 btn_i,
   input  logic [KEY_WIDTH-1:0] key_i,
   reset_sequencer_if.slave     bus,
   output reset_state_e         state_o
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP_CYCLES) ? HOLD_CYCLES : STAGE_GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   reset_state_e           state_q, state_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n;
   logic [NUM_DOMAINS-1:0] dom_q, dom_n, dom_shifted;
   logic                   ready_q, ready_n;
   logic [CAUSE_W-1:0]     cause_q, cause_n;
   logic                   btn_prev_q;
   logic                   lock_s, btn_lvl;
   logic                   loss_ev, btn_ev, sw_ev, wdt_ev, any_ev;

   reset_debounce #(.DEBOUNCE_CYCLES(1)) u_lock_sync (
      .clk(clk), .rst_n(reset_n_i), .d_i(pll_locked_i), .level_o(lock_s)
   );

   reset_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_deb (
      .clk(clk), .rst_n(reset_n_i), .d_i(btn_i), .level_o(btn_lvl)
   );

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);
   logic [WDT_W-1:0] wdt_q;

   // Runs only in RUN; any other state (including the edge that enters RUN) clears it.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i)                                wdt_q <= '0;
      else if (state_q != RUN || bus.wdt_kick_i)     wdt_q <= '0;
      else if (wdt_q == WDT_W'(WDT_CYCLES - 1))      wdt_q <= '0;
      else                                           wdt_q <= wdt_q + 1'b1;
   end

   assign wdt_ev = (state_q == RUN) && !bus.wdt_kick_i && (wdt_q == WDT_W'(WDT_CYCLES - 1));
`else
   logic unused_kick;
   assign unused_kick = bus.wdt_kick_i;
   assign wdt_ev      = 1'b0;
`endif

   assign loss_ev     = !lock_s && (state_q != WAIT_LOCK);
   assign btn_ev      = btn_lvl && !btn_prev_q && (key_i == KEY_WIDTH'(KEY_VALUE));
   assign sw_ev       = bus.sw_reset_req_i;
   assign any_ev      = loss_ev || btn_ev || sw_ev || wdt_ev;
   assign dom_shifted = dom_q << 1;

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= WAIT_LOCK;
         cnt_q      <= '0;
         dom_q      <= '1;
         ready_q    <= 1'b0;
         cause_q    <= CAUSE_W'(1) << CAUSE_POR;
         btn_prev_q <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         dom_q      <= dom_n;
         ready_q    <= ready_n;
         cause_q    <= cause_n;
         btn_prev_q <= btn_lvl;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      dom_n   = dom_q;
      ready_n = ready_q;
      cause_n = cause_q;

      if      (loss_ev) cause_n = CAUSE_W'(1) << CAUSE_PLL_LOSS;
      else if (btn_ev)  cause_n = CAUSE_W'(1) << CAUSE_BUTTON;
      else if (sw_ev)   cause_n = CAUSE_W'(1) << CAUSE_SW;
      else if (wdt_ev)  cause_n = CAUSE_W'(1) << CAUSE_WDT;

      case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_n = HOLD;
               cnt_n   = '0;
            end
         end
         HOLD: begin
            if (loss_ev) begin
               state_n = WAIT_LOCK;
            end else if (any_ev) begin
               cnt_n = '0;
            end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               // Domains release by shifting zeros in from bit 0; all-zero means done.
               cnt_n   = '0;
               dom_n   = dom_shifted;
               ready_n = (dom_shifted == '0);
               state_n = (dom_shifted == '0) ? RUN : RELEASE;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         RELEASE, RUN: begin
            if (any_ev) begin
               dom_n   = '1;
               ready_n = 1'b0;
               cnt_n   = '0;
               state_n = loss_ev ? WAIT_LOCK : HOLD;
            end else if (state_q == RELEASE) begin
               if (cnt_q == CNT_W'(STAGE_GAP_CYCLES - 1)) begin
                  cnt_n   = '0;
                  dom_n   = dom_shifted;
                  ready_n = (dom_shifted == '0);
                  state_n = (dom_shifted == '0) ? RUN : RELEASE;
               end else begin
                  cnt_n = cnt_q + 1'b1;
               end
            end
         end
         default: state_n = WAIT_LOCK;
      endcase
   end

   assign bus.domain_reset_o = dom_q;
   assign bus.all_ready_o    = ready_q;
   assign bus.reset_cause_o  = cause_q;
   assign state_o            = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: staged release, lock loss, button, software, watchdog, async reset.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   logic         clk;
   logic         reset_n;
   logic         pll_locked;
   logic         btn;
   logic [3:0]   key;
   logic         kick_en;
   reset_state_e state;
   int           total;
   int           bad;

   reset_sequencer_if #(.NUM_DOMAINS(3)) bus ();

   reset_sequencer #(
      .NUM_DOMAINS(3), .HOLD_CYCLES(8), .STAGE_GAP_CYCLES(4), .DEBOUNCE_CYCLES(4),
      .KEY_WIDTH(4), .KEY_VALUE(1), .WDT_CYCLES(32)
   ) dut (
      .clk          (clk),
      .reset_n_i    (reset_n),
      .pll_locked_i (pll_locked),
      .btn_i        (btn),
      .key_i        (key),
      .bus          (bus),
      .state_o      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_state(input string tag, input reset_state_e s, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (state == s) break;
         tick(1);
      end
      check(tag, 32'(state), 32'(s));
   endtask

   // Called #1 after the edge that entered HOLD; checks HOLD+k*GAP release points.
   task automatic check_release_seq(input string tag);
      check({tag, "_hold0"}, 32'(bus.domain_reset_o), 32'h7);
      tick(7);
      check({tag, "_hold7"}, 32'(bus.domain_reset_o), 32'h7);
      tick(1);
      check({tag, "_d0"}, 32'(bus.domain_reset_o), 32'h6);
      check({tag, "_st_rel"}, 32'(state), 32'(RELEASE));
      tick(3);
      check({tag, "_d0_gap"}, 32'(bus.domain_reset_o), 32'h6);
      tick(1);
      check({tag, "_d1"}, 32'(bus.domain_reset_o), 32'h4);
      tick(3);
      check({tag, "_d1_gap"}, 32'(bus.domain_reset_o), 32'h4);
      check({tag, "_rdy_lo"}, 32'(bus.all_ready_o), 32'h0);
      tick(1);
      check({tag, "_d2"}, 32'(bus.domain_reset_o), 32'h0);
      check({tag, "_rdy_hi"}, 32'(bus.all_ready_o), 32'h1);
      check({tag, "_st_run"}, 32'(state), 32'(RUN));
   endtask

   // Background kicker: one-cycle pulse every 20 cycles while enabled.
   initial begin
      bus.wdt_kick_i = 1'b0;
      forever begin
         repeat (19) @(posedge clk);
         #1;
         bus.wdt_kick_i = kick_en;
         @(posedge clk);
         #1;
         bus.wdt_kick_i = 1'b0;
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      reset_n = 1'b0;
      pll_locked = 1'b1;
      btn = 1'b0;
      key = 4'd1;
      kick_en = 1'b1;
      bus.sw_reset_req_i = 1'b0;

      // Reset values and first staged release
      tick(3);
      check("por_dom", 32'(bus.domain_reset_o), 32'h7);
      check("por_rdy", 32'(bus.all_ready_o), 32'h0);
      check("por_cause", 32'(bus.reset_cause_o), 32'h01);
      check("por_state", 32'(state), 32'(WAIT_LOCK));
      reset_n = 1'b1;
      tick(2);
      check("t1_sync_wait", 32'(state), 32'(WAIT_LOCK));
      tick(1);
      check("t1_hold", 32'(state), 32'(HOLD));
      check_release_seq("t1");
      check("t1_cause", 32'(bus.reset_cause_o), 32'h01);

      // Lock loss in RUN, then recovery
      tick(5);
      pll_locked = 1'b0;
      tick(2);
      check("t2_before", 32'(bus.domain_reset_o), 32'h0);
      tick(1);
      check("t2_dom", 32'(bus.domain_reset_o), 32'h7);
      check("t2_rdy", 32'(bus.all_ready_o), 32'h0);
      check("t2_cause", 32'(bus.reset_cause_o), 32'h02);
      check("t2_state", 32'(state), 32'(WAIT_LOCK));
      pll_locked = 1'b1;
      wait_state("t2_rehold", HOLD, 10);
      check_release_seq("t2");
      check("t2_sticky", 32'(bus.reset_cause_o), 32'h02);

      // Button: short glitch ignored, valid press with key=1 resets
      btn = 1'b1;
      tick(2);
      btn = 1'b0;
      tick(12);
      check("t3_glitch_dom", 32'(bus.domain_reset_o), 32'h0);
      check("t3_glitch_st", 32'(state), 32'(RUN));
      btn = 1'b1;
      tick(6);
      check("t3_press_pre", 32'(bus.domain_reset_o), 32'h0);
      btn = 1'b0;
      tick(1);
      check("t3_press_dom", 32'(bus.domain_reset_o), 32'h7);
      check("t3_press_cause", 32'(bus.reset_cause_o), 32'h04);
      check("t3_press_st", 32'(state), 32'(HOLD));
      check_release_seq("t3");
      // Same press with the wrong key
      key = 4'd2;
      btn = 1'b1;
      tick(6);
      btn = 1'b0;
      tick(6);
      check("t3_key2_dom", 32'(bus.domain_reset_o), 32'h0);
      check("t3_key2_cause", 32'(bus.reset_cause_o), 32'h04);
      key = 4'd1;
      tick(4);

      // Software request alone: one-cycle latency
      bus.sw_reset_req_i = 1'b1;
      tick(1);
      bus.sw_reset_req_i = 1'b0;
      check("sw_cause", 32'(bus.reset_cause_o), 32'h08);
      check("sw_state", 32'(state), 32'(HOLD));
      check_release_seq("sw");

      // Software request and lock drop together: lock loss wins
      tick(3);
      bus.sw_reset_req_i = 1'b1;
      pll_locked = 1'b0;
      tick(1);
      bus.sw_reset_req_i = 1'b0;
      check("t4_dom", 32'(bus.domain_reset_o), 32'h7);
      tick(2);
      check("t4_cause", 32'(bus.reset_cause_o), 32'h02);
      check("t4_state", 32'(state), 32'(WAIT_LOCK));

      // Watchdog: no kicks for 32 cycles in RUN
      kick_en = 1'b0;
      tick(2);
      pll_locked = 1'b1;
      wait_state("t5_run", RUN, 40);
      tick(31);
      check("t5_pre", 32'(bus.domain_reset_o), 32'h0);
      tick(1);
`ifdef RESET_SEQ_WATCHDOG_EN
      check("t5_wdt_dom", 32'(bus.domain_reset_o), 32'h7);
      check("t5_wdt_cause", 32'(bus.reset_cause_o), 32'h10);
`else
      check("t5_wdt_dom", 32'(bus.domain_reset_o), 32'h0);
      check("t5_wdt_cause", 32'(bus.reset_cause_o), 32'h02);
`endif
      kick_en = 1'b1;
      wait_state("t5_rerun", RUN, 40);
      tick(100);
      check("t5_kick_st", 32'(state), 32'(RUN));
      check("t5_kick_dom", 32'(bus.domain_reset_o), 32'h0);

      // Asynchronous reset mid-RELEASE
      bus.sw_reset_req_i = 1'b1;
      tick(1);
      bus.sw_reset_req_i = 1'b0;
      tick(8);
      check("t6_pre_dom", 32'(bus.domain_reset_o), 32'h6);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_dom", 32'(bus.domain_reset_o), 32'h7);
      check("t6_rdy", 32'(bus.all_ready_o), 32'h0);
      check("t6_cause", 32'(bus.reset_cause_o), 32'h01);
      check("t6_state", 32'(state), 32'(WAIT_LOCK));
      tick(2);
      reset_n = 1'b1;
      wait_state("t6_run", RUN, 40);
      check("t6_cause_run", 32'(bus.reset_cause_o), 32'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
